// File: rtl/sysbus_mem_responder.sv
// Dual-port Sysbus memory responder. Two per-core FSMs share one single-port
// array through a round-robin arbiter and stall their core through Wait.
module sysbus_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              Clock,
    input  logic              nReset,
    inout  wire [DATA_W-1:0]  Sysbus,
    inout  wire [DATA_W-1:0]  Sysbus2,
    input  logic              nME,
    input  logic              nME2,
    input  logic              ALE,
    input  logic              ALE2,
    input  logic              nOE,
    input  logic              nOE2,
    input  logic              nWE,
    input  logic              nWE2,
    output logic              Wait,
    output logic              Wait2,
    output logic [1:0]        Gnt
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_REQ, S_ACC, S_DRIVE} state_t;

    // Index 0 is core 1 (Sysbus), index 1 is core 2 (Sysbus2).
    logic [DATA_W-1:0] bus_in [2];
    logic [1:0]        ale, nme, noe, nwe;

    assign bus_in[0] = Sysbus;
    assign bus_in[1] = Sysbus2;
    assign ale = {ALE2, ALE};
    assign nme = {nME2, nME};
    assign noe = {nOE2, nOE};
    assign nwe = {nWE2, nWE};

    state_t            st_q [2];
    state_t            st_d [2];
    logic [ADDR_W-1:0] addr_q [2];
    logic [DATA_W-1:0] wdata_q [2];
    logic [DATA_W-1:0] rdata_q [2];
    logic [1:0]        is_wr_q;
    logic [1:0]        wait_q, wait_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [3:0]        cnt_q;
    logic              last_grant_q;
    logic [1:0]        lat_addr, lat_req;

    logic acc_port, acc_busy, acc_done, array_free;
    logic grant_any, grant_port;

    // Only one port can be in ACC at a time, so one counter serves both.
    assign acc_port   = (st_q[1] == S_ACC);
    assign acc_busy   = (st_q[0] == S_ACC) || (st_q[1] == S_ACC);
    assign acc_done   = acc_busy && (cnt_q == 4'd1);
    assign array_free = !acc_busy || acc_done;

    always_comb begin
        grant_any  = 1'b0;
        grant_port = 1'b0;
        if (array_free) begin
            if ((st_q[0] == S_REQ) && (st_q[1] == S_REQ)) begin
                grant_any  = 1'b1;
                grant_port = ~last_grant_q;
            end else if (st_q[0] == S_REQ) begin
                grant_any  = 1'b1;
                grant_port = 1'b0;
            end else if (st_q[1] == S_REQ) begin
                grant_any  = 1'b1;
                grant_port = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]     = st_q[i];
            lat_addr[i] = 1'b0;
            lat_req[i]  = 1'b0;
            case (st_q[i])
                S_IDLE, S_ADDR, S_DRIVE: begin
                    if (ale[i] && !nme[i]) begin
                        st_d[i]     = S_ADDR;
                        lat_addr[i] = 1'b1;
                    end else if (st_q[i] == S_ADDR) begin
                        if (!nwe[i] || !noe[i]) begin
                            st_d[i]    = S_REQ;
                            lat_req[i] = 1'b1;
                        end
                    end else if ((st_q[i] == S_DRIVE) && noe[i]) begin
                        st_d[i] = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (grant_any && (grant_port == 1'(i)))
                        st_d[i] = S_ACC;
                end
                S_ACC: begin
                    if (acc_done)
                        st_d[i] = is_wr_q[i] ? S_IDLE : S_DRIVE;
                end
                default: st_d[i] = S_IDLE;
            endcase
            wait_d[i] = (st_d[i] == S_REQ) || (st_d[i] == S_ACC);
        end
    end

    always_comb begin
        if (grant_any)
            gnt_d = grant_port ? 2'b10 : 2'b01;
        else if (acc_done)
            gnt_d = 2'b00;
        else
            gnt_d = gnt_q;
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            for (int i = 0; i < 2; i++)
                st_q[i] <= S_IDLE;
            wait_q       <= 2'b00;
            gnt_q        <= 2'b00;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++)
                st_q[i] <= st_d[i];
            wait_q <= wait_d;
            gnt_q  <= gnt_d;
            if (grant_any) begin
                cnt_q        <= 4'(MEM_LAT);
                last_grant_q <= grant_port;
            end else if (acc_busy) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // nWE wins when both strobes are low in ADDR.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < 2; i++) begin
            if (lat_addr[i])
                addr_q[i] <= bus_in[i][ADDR_W-1:0];
            if (lat_req[i])
                is_wr_q[i] <= !nwe[i];
            if (lat_req[i] && !nwe[i])
                wdata_q[i] <= bus_in[i];
        end
    end

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, mem_re;

    // Gating with nReset makes a reset on the final ACC edge abort the access.
    assign mem_addr = addr_q[acc_port];
    assign mem_we   = nReset && acc_done && is_wr_q[acc_port];
    assign mem_re   = nReset && acc_done && !is_wr_q[acc_port];

    always_ff @(posedge Clock) begin
        if (mem_we)
            mem_q[mem_addr] <= wdata_q[acc_port];
        if (mem_re)
            rdata_q[acc_port] <= mem_q[mem_addr];
    end

    assign Sysbus  = ((st_q[0] == S_DRIVE) && !nOE)  ? rdata_q[0] : {DATA_W{1'bz}};
    assign Sysbus2 = ((st_q[1] == S_DRIVE) && !nOE2) ? rdata_q[1] : {DATA_W{1'bz}};

    assign Wait  = wait_q[0];
    assign Wait2 = wait_q[1];
    assign Gnt   = gnt_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: single-port latency, contention,
// grant order on shared addresses, address aliasing and reset abort.
module tb_sysbus_mem_responder;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        ALE = 1'b0, ALE2 = 1'b0;
    logic        nME = 1'b1, nME2 = 1'b1;
    logic        nOE = 1'b1, nOE2 = 1'b1;
    logic        nWE = 1'b1, nWE2 = 1'b1;
    logic        Wait, Wait2;
    logic [1:0]  Gnt;
    logic        tb_en1 = 1'b0, tb_en2 = 1'b0;
    logic [63:0] tb_d1 = '0, tb_d2 = '0;

    // Pulled low so a released bus reads as zero.
    tri0 [63:0]  Sysbus, Sysbus2;
    assign Sysbus  = tb_en1 ? tb_d1 : 64'bz;
    assign Sysbus2 = tb_en2 ? tb_d2 : 64'bz;

    int          errors = 0;
    int          checks = 0;
    int          n1, n2;
    logic [1:0]  g1, g2;

    sysbus_mem_responder #(.ADDR_W(10), .DATA_W(64), .MEM_LAT(2)) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Sysbus  (Sysbus),
        .Sysbus2 (Sysbus2),
        .nME     (nME),
        .nME2    (nME2),
        .ALE     (ALE),
        .ALE2    (ALE2),
        .nOE     (nOE),
        .nOE2    (nOE2),
        .nWE     (nWE),
        .nWE2    (nWE2),
        .Wait    (Wait),
        .Wait2   (Wait2),
        .Gnt     (Gnt)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic addr_phase(input bit u1, input logic [63:0] a1,
                              input bit u2, input logic [63:0] a2);
        if (u1) begin ALE = 1'b1; nME = 1'b0; tb_en1 = 1'b1; tb_d1 = a1; end
        if (u2) begin ALE2 = 1'b1; nME2 = 1'b0; tb_en2 = 1'b1; tb_d2 = a2; end
        tick();
        ALE = 1'b0; ALE2 = 1'b0; nME = 1'b1; nME2 = 1'b1;
        tb_en1 = 1'b0; tb_en2 = 1'b0;
    endtask

    task automatic strobe(input bit u1, input bit w1, input logic [63:0] d1,
                          input bit u2, input bit w2, input logic [63:0] d2);
        if (u1) begin
            if (w1) begin nWE = 1'b0; tb_en1 = 1'b1; tb_d1 = d1; end
            else nOE = 1'b0;
            $display("txn port1 %s data=0x%0h", w1 ? "write" : "read", d1);
        end
        if (u2) begin
            if (w2) begin nWE2 = 1'b0; tb_en2 = 1'b1; tb_d2 = d2; end
            else nOE2 = 1'b0;
            $display("txn port2 %s data=0x%0h", w2 ? "write" : "read", d2);
        end
        tick();
        nWE = 1'b1; nWE2 = 1'b1; tb_en1 = 1'b0; tb_en2 = 1'b0;
    endtask

    // Counts Wait-high cycles per port and records the first two owners seen.
    task automatic watch(output int c1, output int c2,
                         output logic [1:0] first, output logic [1:0] second);
        c1 = 0; c2 = 0; first = 2'b00; second = 2'b00;
        for (int c = 0; c < 40 && (Wait || Wait2); c++) begin
            if (Wait) c1++;
            if (Wait2) c2++;
            if (Gnt != 2'b00 && first == 2'b00) first = Gnt;
            else if (Gnt != 2'b00 && Gnt != first && second == 2'b00) second = Gnt;
            tick();
        end
    endtask

    task automatic end_reads();
        nOE = 1'b1; nOE2 = 1'b1;
        #1;
        check("bus1_released", Sysbus, 64'd0);
        check("bus2_released", Sysbus2, 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with random strobes.
        for (int k = 0; k < 6; k++) begin
            ALE = 1'($urandom_range(0, 1));  ALE2 = 1'($urandom_range(0, 1));
            nME = 1'($urandom_range(0, 1));  nME2 = 1'($urandom_range(0, 1));
            nOE = 1'($urandom_range(0, 1));  nOE2 = 1'($urandom_range(0, 1));
            nWE = 1'($urandom_range(0, 1));  nWE2 = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_bus1", Sysbus, 64'd0);
        check("rst_bus2", Sysbus2, 64'd0);
        check("rst_wait", Wait, 1'b0);
        check("rst_wait2", Wait2, 1'b0);
        check("rst_gnt", Gnt, 2'b00);
        ALE = 0; ALE2 = 0; nME = 1; nME2 = 1; nOE = 1; nOE2 = 1; nWE = 1; nWE2 = 1;
        nReset = 1'b1;
        tick(); tick(); tick();
        check("post_rst_wait", Wait, 1'b0);
        check("post_rst_gnt", Gnt, 2'b00);
        nOE = 1'b0;
        tick(); tick();
        check("no_ale_wait", Wait, 1'b0);
        check("no_ale_bus1", Sysbus, 64'd0);
        nOE = 1'b1;
        tick();

        // Port1 write then read of 0x005.
        addr_phase(1, 64'h005, 0, 64'h0);
        strobe(1, 1, 64'hDEADBEEF_01234567, 0, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("wr005_wait_cycles", 64'(n1), 64'd3);
        check("wr005_gnt", g1, 2'b01);
        addr_phase(1, 64'h005, 0, 64'h0);
        strobe(1, 0, 64'h0, 0, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("rd005_wait_cycles", 64'(n1), 64'd3);
        check("rd005_data", Sysbus, 64'hDEADBEEF_01234567);
        end_reads();

        // Port2 preloads 0x010 and 0x030.
        addr_phase(0, 64'h0, 1, 64'h010);
        strobe(0, 0, 64'h0, 1, 1, 64'h1111);
        watch(n1, n2, g1, g2);
        check("pre010_wait2_cycles", 64'(n2), 64'd3);
        check("pre010_gnt", g1, 2'b10);
        addr_phase(0, 64'h0, 1, 64'h030);
        strobe(0, 0, 64'h0, 1, 1, 64'h3333);
        watch(n1, n2, g1, g2);
        check("pre030_wait2_cycles", 64'(n2), 64'd3);

        // Simultaneous reads of 0x010, port1 wins the tie.
        addr_phase(1, 64'h010, 1, 64'h010);
        strobe(1, 0, 64'h0, 1, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("tie_rd_wait1", 64'(n1), 64'd3);
        check("tie_rd_wait2", 64'(n2), 64'd5);
        check("tie_rd_first_gnt", g1, 2'b01);
        check("tie_rd_second_gnt", g2, 2'b10);
        check("tie_rd_bus1", Sysbus, 64'h1111);
        check("tie_rd_bus2", Sysbus2, 64'h1111);
        end_reads();

        // Port1 writes 0xAAAA while port2 reads 0x030; port1 granted first.
        addr_phase(1, 64'h030, 1, 64'h030);
        strobe(1, 1, 64'hAAAA, 1, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("rw_p1first_wait1", 64'(n1), 64'd3);
        check("rw_p1first_wait2", 64'(n2), 64'd5);
        check("rw_p1first_gnt", g1, 2'b01);
        check("rw_p1first_bus2", Sysbus2, 64'hAAAA);
        end_reads();

        // ALE with nME=1 is ignored.
        ALE = 1'b1; nME = 1'b1; tb_en1 = 1'b1; tb_d1 = 64'h005;
        tick();
        ALE = 1'b0; tb_en1 = 1'b0; nOE = 1'b0;
        tick(); tick();
        check("ale_nme1_wait", Wait, 1'b0);
        check("ale_nme1_bus1", Sysbus, 64'd0);
        nOE = 1'b1;
        tick();

        // 0x405 aliases 0x005.
        addr_phase(1, 64'h0000_0000_0000_0405, 0, 64'h0);
        strobe(1, 0, 64'h0, 0, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("alias_wait_cycles", 64'(n1), 64'd3);
        check("alias_data", Sysbus, 64'hDEADBEEF_01234567);
        end_reads();

        // last_grant is port1 now, so port2 wins and reads the old value.
        addr_phase(1, 64'h030, 1, 64'h030);
        strobe(1, 1, 64'hBBBB, 1, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("rw_p2first_wait1", 64'(n1), 64'd5);
        check("rw_p2first_wait2", 64'(n2), 64'd3);
        check("rw_p2first_first_gnt", g1, 2'b10);
        check("rw_p2first_second_gnt", g2, 2'b01);
        check("rw_p2first_bus2", Sysbus2, 64'hAAAA);
        end_reads();
        addr_phase(1, 64'h030, 0, 64'h0);
        strobe(1, 0, 64'h0, 0, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("rd030_after_wr", Sysbus, 64'hBBBB);
        end_reads();

        // Reset on the committing edge of a write to 0x020.
        addr_phase(1, 64'h020, 0, 64'h0);
        strobe(1, 1, 64'h1234, 0, 0, 64'h0);
        watch(n1, n2, g1, g2);
        addr_phase(1, 64'h020, 0, 64'h0);
        strobe(1, 1, 64'h55, 0, 0, 64'h0);
        tick(); tick();
        check("abort_pre_gnt", Gnt, 2'b01);
        check("abort_pre_wait", Wait, 1'b1);
        nReset = 1'b0;
        tick();
        check("abort_wait", Wait, 1'b0);
        check("abort_gnt", Gnt, 2'b00);
        nReset = 1'b1;
        tick(); tick();
        addr_phase(1, 64'h020, 0, 64'h0);
        strobe(1, 0, 64'h0, 0, 0, 64'h0);
        watch(n1, n2, g1, g2);
        check("abort_rd_wait_cycles", 64'(n1), 64'd3);
        check("abort_rd_data", Sysbus, 64'h1234);
        end_reads();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Dual-port system-bus memory responder sitting at the far end of both cores' Sysbus/Sysbus2.
- Latches an address phase from each core, then serves its read (drives data back onto the bus for the core to load into DR) or its write (captures data the core drives from ALU/PC/Rs2).
- Both ports share one single-port memory array. A round-robin arbiter serialises the accesses and stalls each core through its Wait line.

Parameters:
- ADDR_W, 10, memory address width; words = 2**ADDR_W; upper Sysbus address bits ignored (address wraps modulo depth)
- DATA_W, 64, word width; must equal bus width
- MEM_LAT, 2, cycles a granted access occupies the array; legal range 1..15

Ports:
- Clock  input  1  rising-edge clock
- nReset  input  1  reset; synchronous, active-low
- Sysbus  inout  DATA_W  core-1 bus: address/write data in, read data out
- Sysbus2  inout  DATA_W  core-2 bus, same use
- nME  input  1  core-1 memory select, active-low
- nME2  input  1  core-2 memory select, active-low
- ALE  input  1  core-1 address latch enable
- ALE2  input  1  core-2 address latch enable
- nOE  input  1  core-1 read strobe, active-low
- nOE2  input  1  core-2 read strobe, active-low
- nWE  input  1  core-1 write strobe, active-low
- nWE2  input  1  core-2 write strobe, active-low
- Wait  output  1  core-1 stall; high while an access is pending
- Wait2  output  1  core-2 stall
- Gnt  output  2  current array owner: 00 none, 01 port1, 10 port2

Behaviour:
- Port FSMs. Each port runs an identical FSM: IDLE, ADDR, REQ, ACC, DRIVE.
- Reset. On nReset=0 at a rising edge:
  - both FSMs go to IDLE; Wait=Wait2=0; Gnt=00
  - both buses are released (z)
  - last_grant=port2, so port1 wins the first tie
  - memory contents are not reset
  - reset during ACC aborts the access: no write commit, no data driven
- IDLE/ADDR/DRIVE + ALE=1 + nME=0:
  - latch addr = bus[ADDR_W-1:0]; go to ADDR
  - ALE with nME=1 is ignored
  - a new ALE aborts DRIVE
- ADDR:
  - nWE=0: latch wdata from the bus; go to REQ(write)
  - else nOE=0: go to REQ(read)
  - nWE has priority if both strobes are low
- Wait. Wait=1 exactly while the port state is REQ or ACC. It is registered (asserted after the edge that enters REQ).
- Arbiter:
  - The array is free when no port is in ACC, or when the port in ACC finishes at this edge (back-to-back grants allowed).
  - A free array goes to the single requester, or on a tie to the port opposite last_grant.
  - The granted port moves REQ->ACC and loads counter = MEM_LAT; last_grant is updated; Gnt shows the owner during ACC.
- ACC:
  - the counter decrements each edge
  - on the edge where the counter reaches 1, read: rdata = mem[addr], go to DRIVE
  - same edge, write: mem[addr] = wdata, go to IDLE
- DRIVE:
  - bus is driven with rdata while nOE=0, otherwise z
  - the edge that samples nOE=1 returns the port to IDLE
- The bus is driven only in DRIVE with nOE=0; it is z in every other state.
- Uncontested latency:
  - strobe sampled at edge T → REQ at T
  - ACC at T+1
  - done at T+1+MEM_LAT
  - Wait high 1+MEM_LAT cycles (3 at default)
- Contested:
  - the loser enters ACC on the edge the winner finishes
  - loser Wait is high 1+2*MEM_LAT cycles
- Same-address read/write from both ports follows grant order; the later access observes the earlier write.
- Strobes deasserted during REQ/ACC are ignored; the access completes.

Test Plan:
- Reset with random strobes:
  - bus z, Wait=Wait2=0, Gnt=00
  - after release, port1 idle until ALE
- Port1 write then read, MEM_LAT=2:
  - ALE addr 0x005; nWE data 0xDEADBEEF_01234567 → Wait high 3 cycles
  - ALE addr 0x005; nOE → Wait high 3 cycles, then Sysbus=0xDEADBEEF_01234567 while nOE=0, z after nOE=1
- Simultaneous reads, both ports addr 0x010 (preloaded 0x1111):
  - port1 granted first: Wait 3 cycles, Gnt=01
  - port2: Wait 5 cycles, Gnt=10
  - both return 0x1111
  - next tie is granted to port1 again only after port2 has been granted
- Same address, port1 write 0xAAAA and port2 read, same cycle:
  - port1 granted; port2 reads 0xAAAA
  - repeat with port2 granted first (last_grant=port1): port2 reads the old value
- Address 0x0000_0000_0000_0405 with ADDR_W=10 aliases 0x005; ALE with nME=1 leaves the FSM in IDLE and Wait=0.
- nReset=0 mid-ACC write of 0x55 to addr 0x020:
  - Wait drops, Gnt=00
  - a later read of 0x020 returns the prior contents, not 0x55
